gcm_ctrl: RTL and testbench

Sequencer for one AES-GCM operation on full 128-bit blocks. It drives one shared GCTR instance and one GHASH instance through the whole message: AAD hashing, CTR encryption or decryption of text blocks, the length block, and the final tag encryption. It sits between the AXI-stream front end and the `gctr`/`ghash`/AES-core datapath. Partial blocks are handled upstream.

---
 rtl/gcm_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_gcm_ctrl.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_ctrl.sv
// gcm_ctrl: sequencer for one AES-GCM operation over full 128-bit blocks.
//
// Drives a shared GCTR unit and a GHASH unit through AAD hashing, CTR
// encryption/decryption of text blocks, the length block and the final
// tag encryption. The GCTR and GHASH units get one request at a time:
// each request is a one-cycle *_en pulse, and the controller waits for
// the matching *_done.
//
// Parameters:
//   CNT_BITS      width of the AAD / text block counters
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   start, encrypt, j0, subkey_h,    operation request; all operands are
//   aad_blocks, txt_blocks, exp_tag  latched on start while idle
//   in_valid/in_ready/in_blk         input blocks: AAD first, then text
//   out_valid/out_ready/out_blk      text result stream
//   tag_valid, tag, tag_ok           final tag (tag_valid is a 1-cycle pulse)
//   busy                             high whenever not idle
//   gctr_en/gctr_icb/gctr_data       GCTR request
//   gctr_out_blk/gctr_done           GCTR result
//   ghash_en/ghash_prev/ghash_data/  GHASH request (subkey is the latched H)
//   ghash_subkey
//   ghash_result/ghash_done          GHASH result
//
// Configuration macro:
//   GCM_CTRL_TAG_CHECK_EN  when defined, a decrypt compares the computed
//                          tag against exp_tag and reports it on tag_ok.
//                          When undefined, tag_ok is tied low and exp_tag
//                          is ignored.
module gcm_ctrl #(
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                encrypt,
    input  logic [127:0]        j0,
    input  logic [127:0]        subkey_h,
    input  logic [CNT_BITS-1:0] aad_blocks,
    input  logic [CNT_BITS-1:0] txt_blocks,
    input  logic [127:0]        exp_tag,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_blk,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_blk,
    output logic                tag_valid,
    output logic [127:0]        tag,
    output logic                tag_ok,
    output logic                busy,
    output logic                gctr_en,
    output logic [127:0]        gctr_icb,
    output logic [127:0]        gctr_data,
    input  logic [127:0]        gctr_out_blk,
    input  logic                gctr_done,
    output logic                ghash_en,
    output logic [127:0]        ghash_prev,
    output logic [127:0]        ghash_data,
    output logic [127:0]        ghash_subkey,
    input  logic [127:0]        ghash_result,
    input  logic                ghash_done
);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        AAD_H,
        TXT_C,
        TXT_O,
        TXT_H,
        LEN_H,
        TAG_C,
        FIN
    } state_t;

    state_t               state;
    logic                 enc_reg;
    logic [127:0]         j0_reg;
    logic [127:0]         h_reg;
    logic [CNT_BITS-1:0]  aad_total;
    logic [CNT_BITS-1:0]  txt_total;
    logic [CNT_BITS-1:0]  aad_cnt;
    logic [CNT_BITS-1:0]  txt_cnt;
    logic [127:0]         ctr;
    logic [127:0]         s_acc;
    logic [127:0]         blk;
    logic                 has_work;
    logic [63:0]          aad_bits;
    logic [63:0]          txt_bits;

    // Only the low 32-bit word counts; it wraps without carrying into bit 32.
    function automatic logic [127:0] inc32(input logic [127:0] x);
        return {x[127:32], x[31:0] + 32'd1};
    endfunction

    assign has_work     = (aad_cnt != '0) || (txt_cnt != '0);
    assign in_ready     = (state == FETCH) && has_work;
    assign ghash_subkey = h_reg;

    // Bit lengths for the length block: block counts times 128.
    assign aad_bits = 64'(aad_total) << 7;
    assign txt_bits = 64'(txt_total) << 7;

`ifdef GCM_CTRL_TAG_CHECK_EN
    logic [127:0] exp_tag_reg;
    logic         tag_ok_reg;
    assign tag_ok = tag_ok_reg;
`else
    logic unused_exp_tag;
    assign unused_exp_tag = ^exp_tag;
    assign tag_ok = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            enc_reg    <= 1'b0;
            j0_reg     <= '0;
            h_reg      <= '0;
            aad_total  <= '0;
            txt_total  <= '0;
            aad_cnt    <= '0;
            txt_cnt    <= '0;
            ctr        <= '0;
            s_acc      <= '0;
            blk        <= '0;
            out_valid  <= 1'b0;
            out_blk    <= '0;
            tag_valid  <= 1'b0;
            tag        <= '0;
            busy       <= 1'b0;
            gctr_en    <= 1'b0;
            gctr_icb   <= '0;
            gctr_data  <= '0;
            ghash_en   <= 1'b0;
            ghash_prev <= '0;
            ghash_data <= '0;
`ifdef GCM_CTRL_TAG_CHECK_EN
            exp_tag_reg <= '0;
            tag_ok_reg  <= 1'b0;
`endif
        end else begin
            // Request strobes and the tag strobe are single-cycle pulses.
            gctr_en   <= 1'b0;
            ghash_en  <= 1'b0;
            tag_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        enc_reg   <= encrypt;
                        j0_reg    <= j0;
                        h_reg     <= subkey_h;
                        aad_total <= aad_blocks;
                        txt_total <= txt_blocks;
                        aad_cnt   <= aad_blocks;
                        txt_cnt   <= txt_blocks;
                        ctr       <= inc32(j0);
                        s_acc     <= '0;
                        busy      <= 1'b1;
`ifdef GCM_CTRL_TAG_CHECK_EN
                        exp_tag_reg <= exp_tag;
                        tag_ok_reg  <= 1'b0;
`endif
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    if (has_work) begin
                        if (in_valid) begin
                            blk <= in_blk;
                            if (aad_cnt != '0) begin
                                ghash_en   <= 1'b1;
                                ghash_prev <= s_acc;
                                ghash_data <= in_blk;
                                state      <= AAD_H;
                            end else begin
                                gctr_en   <= 1'b1;
                                gctr_icb  <= ctr;
                                gctr_data <= in_blk;
                                state     <= TXT_C;
                            end
                        end
                    end else begin
                        ghash_en   <= 1'b1;
                        ghash_prev <= s_acc;
                        ghash_data <= {aad_bits, txt_bits};
                        state      <= LEN_H;
                    end
                end

                AAD_H: begin
                    if (ghash_done) begin
                        s_acc   <= ghash_result;
                        aad_cnt <= aad_cnt - CNT_BITS'(1);
                        state   <= FETCH;
                    end
                end

                TXT_C: begin
                    if (gctr_done) begin
                        out_blk   <= gctr_out_blk;
                        out_valid <= 1'b1;
                        ctr       <= inc32(ctr);
                        state     <= TXT_O;
                    end
                end

                // GHASH always absorbs ciphertext: the GCTR result when
                // encrypting, the original input block when decrypting.
                TXT_O: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        ghash_en   <= 1'b1;
                        ghash_prev <= s_acc;
                        ghash_data <= enc_reg ? out_blk : blk;
                        state      <= TXT_H;
                    end
                end

                TXT_H: begin
                    if (ghash_done) begin
                        s_acc   <= ghash_result;
                        txt_cnt <= txt_cnt - CNT_BITS'(1);
                        state   <= FETCH;
                    end
                end

                LEN_H: begin
                    if (ghash_done) begin
                        s_acc     <= ghash_result;
                        gctr_en   <= 1'b1;
                        gctr_icb  <= j0_reg;
                        gctr_data <= ghash_result;
                        state     <= TAG_C;
                    end
                end

                TAG_C: begin
                    if (gctr_done) begin
                        tag       <= gctr_out_blk;
                        tag_valid <= 1'b1;
`ifdef GCM_CTRL_TAG_CHECK_EN
                        tag_ok_reg <= !enc_reg && (gctr_out_blk == exp_tag_reg);
`endif
                        state <= FIN;
                    end
                end

                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcm_ctrl.sv
// tb_gcm_ctrl: self-checking bench for gcm_ctrl.
//
// GCTR and GHASH are emulated inside the bench with adjustable latency.
// GHASH is a true GF(2^128) multiply; the block cipher is a stand-in that
// returns the real all-zero-key AES output for counters 1 and 2 and a
// fixed mixing function for every other counter. A per-operation model
// builds the expected request, output and tag sequences from the GCM
// definition, and a compare process checks the DUT on every cycle.
module tb_gcm_ctrl;

    localparam logic [127:0] H_ZK   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] J0_ONE = 128'h00000000000000000000000000000001;
    localparam logic [127:0] EK_J0  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] EK_J1  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] TAG2   = 128'hab6e47d42cec13bdf53a67b21257bddf;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         encrypt;
    logic [127:0] j0;
    logic [127:0] subkey_h;
    logic [15:0]  aad_blocks;
    logic [15:0]  txt_blocks;
    logic [127:0] exp_tag;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_blk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_blk;
    logic         tag_valid;
    logic [127:0] tag;
    logic         tag_ok;
    logic         busy;
    logic         gctr_en;
    logic [127:0] gctr_icb;
    logic [127:0] gctr_data;
    logic [127:0] gctr_out_blk = '0;
    logic         gctr_done = 1'b0;
    logic         ghash_en;
    logic [127:0] ghash_prev;
    logic [127:0] ghash_data;
    logic [127:0] ghash_subkey;
    logic [127:0] ghash_result = '0;
    logic         ghash_done = 1'b0;

    gcm_ctrl #(.CNT_BITS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .encrypt      (encrypt),
        .j0           (j0),
        .subkey_h     (subkey_h),
        .aad_blocks   (aad_blocks),
        .txt_blocks   (txt_blocks),
        .exp_tag      (exp_tag),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_blk       (in_blk),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_blk      (out_blk),
        .tag_valid    (tag_valid),
        .tag          (tag),
        .tag_ok       (tag_ok),
        .busy         (busy),
        .gctr_en      (gctr_en),
        .gctr_icb     (gctr_icb),
        .gctr_data    (gctr_data),
        .gctr_out_blk (gctr_out_blk),
        .gctr_done    (gctr_done),
        .ghash_en     (ghash_en),
        .ghash_prev   (ghash_prev),
        .ghash_data   (ghash_data),
        .ghash_subkey (ghash_subkey),
        .ghash_result (ghash_result),
        .ghash_done   (ghash_done)
    );

    always #5 clk = ~clk;

    int vecCount  = 0;
    int missCount = 0;

    logic [255:0] gcExp[$];
    logic [255:0] ghExp[$];
    logic [127:0] outExp[$];
    logic [127:0] icbLog[$];
    logic [127:0] tagExp;
    logic         tagOkExp;
    logic [127:0] hExp;
    logic         noInReady = 1'b0;
    logic         tagSeen = 1'b0;
    logic [127:0] lastOut;
    logic [127:0] lastTag;
    logic         lastTagOk;
    int           enTotal = 0;

    logic [127:0] aadMem[4];
    logic [127:0] txtMem[4];

    int gcLat = 2;
    int ghLat = 3;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name, input string why);
        vecCount++;
        missCount++;
        $display("[TB] FAIL %s: %s", name, why);
    endtask

    function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z;
        logic [127:0] v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
            else      v = v >> 1;
        end
        return z;
    endfunction

    // Zero-key AES outputs for counters 1 and 2 are exact; other counters
    // get an arbitrary but deterministic keystream.
    function automatic logic [127:0] ks(input logic [127:0] icb);
        logic [31:0] m;
        if (icb == J0_ONE) return EK_J0;
        if (icb == 128'h2) return EK_J1;
        m = icb[31:0] * 32'h9e3779b9;
        return {icb[95:0], icb[127:96]} ^ 128'h243f6a8885a308d313198a2e03707344 ^ {4{m}};
    endfunction

    // GCTR / GHASH emulation. A request left pending across a reset still
    // completes, producing a stale done.
    logic         gcPend = 1'b0;
    logic         ghPend = 1'b0;
    int           gcCnt;
    int           ghCnt;
    logic [127:0] gcIcb;
    logic [127:0] gcData;
    logic [127:0] ghPrev;
    logic [127:0] ghData;
    logic [127:0] ghH;

    always @(negedge clk) begin
        gctr_done = 1'b0;
        if (gcPend) begin
            if (gcCnt == 0) begin
                gctr_done    = 1'b1;
                gctr_out_blk = ks(gcIcb) ^ gcData;
                gcPend       = 1'b0;
            end else begin
                gcCnt--;
            end
        end
        if (gctr_en === 1'b1) begin
            gcPend = 1'b1;
            gcCnt  = gcLat;
            gcIcb  = gctr_icb;
            gcData = gctr_data;
        end
    end

    always @(negedge clk) begin
        ghash_done = 1'b0;
        if (ghPend) begin
            if (ghCnt == 0) begin
                ghash_done   = 1'b1;
                ghash_result = gmul(ghPrev ^ ghData, ghH);
                ghPend       = 1'b0;
            end else begin
                ghCnt--;
            end
        end
        if (ghash_en === 1'b1) begin
            ghPend = 1'b1;
            ghCnt  = ghLat;
            ghPrev = ghash_prev;
            ghData = ghash_data;
            ghH    = ghash_subkey;
        end
    end

    // Compare process.
    always @(negedge clk) begin
        logic [255:0] e;
        if (reset === 1'b0) begin
            if (gctr_en === 1'b1) begin
                enTotal++;
                icbLog.push_back(gctr_icb);
                if (gcExp.size() == 0) failNow("gctr_en", "request issued with none expected");
                else begin
                    e = gcExp.pop_front();
                    checkOutput("gctr_icb", gctr_icb, e[255:128]);
                    checkOutput("gctr_data", gctr_data, e[127:0]);
                end
            end
            if (ghash_en === 1'b1) begin
                enTotal++;
                if (ghExp.size() == 0) failNow("ghash_en", "request issued with none expected");
                else begin
                    e = ghExp.pop_front();
                    checkOutput("ghash_prev", ghash_prev, e[255:128]);
                    checkOutput("ghash_data", ghash_data, e[127:0]);
                    checkOutput("ghash_subkey", ghash_subkey, hExp);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                lastOut = out_blk;
                if (outExp.size() == 0) failNow("out_valid", "output with none expected");
                else checkOutput("out_blk", out_blk, outExp.pop_front());
            end
            if (tag_valid === 1'b1) begin
                lastTag   = tag;
                lastTagOk = tag_ok;
                checkOutput("tag", tag, tagExp);
                checkOutput("tag_ok", tag_ok, tagOkExp);
                tagSeen = 1'b1;
            end
            if (noInReady) checkOutput("in_ready_empty", in_ready, 1'b0);
        end
    end

    task automatic buildModel(input logic enc, input logic [127:0] j0v, input logic [127:0] hv,
                              input int na, input int nt, input logic [127:0] etag);
        logic [127:0] s;
        logic [127:0] icb;
        logic [127:0] r;
        logic [127:0] c;
        logic [127:0] lenB;
        gcExp.delete();
        ghExp.delete();
        outExp.delete();
        icbLog.delete();
        tagSeen = 1'b0;
        hExp = hv;
        s = '0;
        for (int i = 0; i < na; i++) begin
            ghExp.push_back({s, aadMem[i]});
            s = gmul(s ^ aadMem[i], hv);
        end
        for (int i = 0; i < nt; i++) begin
            icb = {j0v[127:32], j0v[31:0] + 32'(i + 1)};
            r = txtMem[i] ^ ks(icb);
            gcExp.push_back({icb, txtMem[i]});
            outExp.push_back(r);
            c = enc ? r : txtMem[i];
            ghExp.push_back({s, c});
            s = gmul(s ^ c, hv);
        end
        lenB = {64'(na) * 64'd128, 64'(nt) * 64'd128};
        ghExp.push_back({s, lenB});
        s = gmul(s ^ lenB, hv);
        gcExp.push_back({j0v, s});
        tagExp = ks(j0v) ^ s;
`ifdef GCM_CTRL_TAG_CHECK_EN
        tagOkExp = !enc && (tagExp == etag);
`else
        tagOkExp = 1'b0;
`endif
    endtask

    task automatic pulseStart(input logic enc, input logic [127:0] j0v, input logic [127:0] hv,
                              input int na, input int nt, input logic [127:0] etag);
        @(posedge clk); #1;
        start = 1'b1; encrypt = enc; j0 = j0v; subkey_h = hv;
        aad_blocks = 16'(na); txt_blocks = 16'(nt); exp_tag = etag;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1'b1);
        checkOutput("tag_ok_cleared", tag_ok, 1'b0);
        // Operands must already be latched; scramble them.
        encrypt = ~enc; j0 = ~j0v; subkey_h = ~hv; exp_tag = ~etag;
        aad_blocks = 16'hffff; txt_blocks = 16'hffff;
    endtask

    task automatic feedBlock(input logic [127:0] b);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_blk = b;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) failNow("in_ready_wait", "in_ready never rose within 500 cycles");
    endtask

    task automatic applyStimulus(input logic enc, input logic [127:0] j0v, input logic [127:0] hv,
                                 input int na, input int nt, input logic [127:0] etag, input logic stall);
        buildModel(enc, j0v, hv, na, nt, etag);
        noInReady = (na == 0 && nt == 0);
        out_ready = !stall;
        pulseStart(enc, j0v, hv, na, nt, etag);
        fork
            begin
                for (int i = 0; i < na + nt; i++)
                    feedBlock(i < na ? aadMem[i] : txtMem[i - na]);
            end
            begin
                if (stall) begin
                    logic [127:0] b0;
                    int e0;
                    int bad;
                    logic seen;
                    seen = 1'b0;
                    for (int k = 0; k < 500 && !seen; k++) begin
                        @(posedge clk); #1;
                        if (out_valid) seen = 1'b1;
                    end
                    if (!seen) failNow("stall_out_valid", "out_valid never rose within 500 cycles");
                    b0 = out_blk;
                    e0 = enTotal;
                    bad = 0;
                    for (int i = 0; i < 20; i++) begin
                        @(posedge clk); #1;
                        if (out_blk !== b0 || out_valid !== 1'b1) bad++;
                        if (i == 5) begin start = 1'b1; encrypt = ~enc; end
                        if (i == 6) start = 1'b0;
                    end
                    checkOutput("stall_out_stable", 128'(bad), 128'd0);
                    checkOutput("stall_no_requests", 128'(enTotal), 128'(e0));
                    checkOutput("stall_busy", busy, 1'b1);
                    out_ready = 1'b1;
                end
            end
            begin
                for (int k = 0; k < 3000 && !tagSeen; k++) begin
                    @(posedge clk); #1;
                end
                if (!tagSeen) failNow("tag_wait", "tag_valid never seen within 3000 cycles");
            end
        join
        noInReady = 1'b0;
        @(posedge clk); #1;
        checkOutput("tag_valid_pulse", tag_valid, 1'b0);
        checkOutput("busy_done", busy, 1'b0);
        checkOutput("tag_held", tag, tagExp);
        checkOutput("tag_ok_held", tag_ok, tagOkExp);
        checkOutput("gctr_queue_drained", 128'(gcExp.size()), 128'd0);
        checkOutput("ghash_queue_drained", 128'(ghExp.size()), 128'd0);
        checkOutput("out_queue_drained", 128'(outExp.size()), 128'd0);
    endtask

    task automatic checkAllZero(input string tagName);
        checkOutput({tagName, "_busy"}, busy, 1'b0);
        checkOutput({tagName, "_in_ready"}, in_ready, 1'b0);
        checkOutput({tagName, "_out_valid"}, out_valid, 1'b0);
        checkOutput({tagName, "_tag_valid"}, tag_valid, 1'b0);
        checkOutput({tagName, "_tag_ok"}, tag_ok, 1'b0);
        checkOutput({tagName, "_gctr_en"}, gctr_en, 1'b0);
        checkOutput({tagName, "_ghash_en"}, ghash_en, 1'b0);
        checkOutput({tagName, "_out_blk"}, out_blk, '0);
        checkOutput({tagName, "_tag"}, tag, '0);
    endtask

    initial begin
        logic [127:0] j0w;
        logic [127:0] v;
        reset = 1'b1; start = 1'b0; encrypt = 1'b0; j0 = '0; subkey_h = '0;
        aad_blocks = '0; txt_blocks = '0; exp_tag = '0;
        in_valid = 1'b0; in_blk = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        reset = 1'b0;

        // Empty message: the tag is E(K, J0).
        applyStimulus(1'b1, J0_ONE, H_ZK, 0, 0, '0, 1'b0);
        checkOutput("empty_tag_kat", lastTag, EK_J0);

        // One zero text block, encrypt.
        txtMem[0] = '0;
        gcLat = 0; ghLat = 1;
        applyStimulus(1'b1, J0_ONE, H_ZK, 0, 1, '0, 1'b0);
        checkOutput("enc_out_kat", lastOut, EK_J1);
        checkOutput("enc_tag_kat", lastTag, TAG2);

        // Decrypt the same block back.
        txtMem[0] = EK_J1;
        gcLat = 4; ghLat = 0;
        applyStimulus(1'b0, J0_ONE, H_ZK, 0, 1, TAG2, 1'b0);
        checkOutput("dec_out_kat", lastOut, '0);
        checkOutput("dec_tag_kat", lastTag, TAG2);
`ifdef GCM_CTRL_TAG_CHECK_EN
        checkOutput("dec_tag_ok_kat", lastTagOk, 1'b1);
`else
        checkOutput("dec_tag_ok_kat", lastTagOk, 1'b0);
`endif

        // Wrong expected tag.
        applyStimulus(1'b0, J0_ONE, H_ZK, 0, 1, TAG2 ^ 128'h1, 1'b0);
        checkOutput("dec_bad_tag_ok", lastTagOk, 1'b0);

        // Counter wrap with AAD in front.
        j0w = {96'hcafebabe_deadbeef_01234567, 32'hfffffffe};
        aadMem[0] = 128'h000102030405060708090a0b0c0d0e0f;
        aadMem[1] = 128'hfeedfacedeadbeef0badf00d12345678;
        txtMem[0] = 128'h11111111222222223333333344444444;
        txtMem[1] = 128'h0;
        txtMem[2] = 128'hffffffffffffffffffffffffffffffff;
        gcLat = 3; ghLat = 2;
        applyStimulus(1'b1, j0w, H_ZK, 2, 3, '0, 1'b0);
        checkOutput("wrap_icb_count", 128'(icbLog.size()), 128'd4);
        if (icbLog.size() == 4) begin
            v = icbLog[0];
            checkOutput("wrap_icb0", v, {96'hcafebabe_deadbeef_01234567, 32'hffffffff});
            v = icbLog[1];
            checkOutput("wrap_icb1", v, {96'hcafebabe_deadbeef_01234567, 32'h00000000});
            v = icbLog[2];
            checkOutput("wrap_icb2", v, {96'hcafebabe_deadbeef_01234567, 32'h00000001});
            v = icbLog[3];
            checkOutput("wrap_tag_icb", v, j0w);
        end

        // Output back-pressure with a start pulse while busy.
        aadMem[0] = 128'h0123456789abcdef0123456789abcdef;
        txtMem[0] = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;
        txtMem[1] = 128'h00000000000000000000000000000080;
        gcLat = 1; ghLat = 1;
        applyStimulus(1'b1, j0w, H_ZK, 1, 2, '0, 1'b1);

        // Reset while waiting for GCTR; its late done must be ignored.
        txtMem[0] = 128'h0;
        gcLat = 6; ghLat = 1;
        buildModel(1'b1, J0_ONE, H_ZK, 0, 1, '0);
        pulseStart(1'b1, J0_ONE, H_ZK, 0, 1, '0);
        feedBlock(128'h0);
        checkOutput("txt_c_gctr_en", gctr_en, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("midreset");
        gcExp.delete(); ghExp.delete(); outExp.delete();
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("stale_busy", busy, 1'b0);
        checkOutput("stale_out_valid", out_valid, 1'b0);
        checkOutput("stale_out_blk", out_blk, '0);
        checkOutput("stale_gctr_en", gctr_en, 1'b0);

        // Normal operation after the abort: decrypt with AAD.
        aadMem[0] = 128'h9999888877776666555544443333222f;
        txtMem[0] = 128'h0badc0de0badc0de0badc0de0badc0de;
        txtMem[1] = EK_J1;
        gcLat = 2; ghLat = 2;
        applyStimulus(1'b0, J0_ONE, H_ZK, 1, 2, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
